// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lsu
//  Description : Data-memory load/store unit. Accepts one CPU load or store
//                at a time, stalls the pipeline while it drives a
//                single-port SRAM, and returns aligned, extended load data.
//                Misaligned or illegal accesses raise a one-cycle error
//                without touching the SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  output logic [31:0]       resp_rdata,
  output logic              stall,
  output logic              err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              write_q;
  logic              illegal_q;
  logic [31:0]       rdata_q;

  logic              w_req;
  logic              w_illegal;
  logic              w_latch;
  logic              w_capture;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic              w_unused_addr;

  // Address bits above the SRAM range are deliberately dropped (addresses wrap).
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  assign w_req      = req_read | req_write;
  assign sram_addr  = addr_q[ADDR_W+1:2];
  assign resp_rdata = rdata_q;

  // Classify the incoming request; a simultaneous read+write counts as a write.
  always_comb begin
    w_illegal = 1'b0;
    case (req_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = req_addr[0];
      3'b010:  w_illegal = |req_addr[1:0];
      3'b100:  w_illegal = req_write;
      3'b101:  w_illegal = req_write | req_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // State register; reset returns to IDLE at once so SRAM strobes drop immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    err       = 1'b0;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          stall   = 1'b1;
          w_latch = 1'b1;
          state_d = w_illegal ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall   = 1'b1;
        sram_en = 1'b1;
        sram_we = write_q;
        state_d = write_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall     = 1'b1;
        w_capture = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        // A request visible here belongs to the retiring instruction; ignore it.
        err     = illegal_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture registers, loaded only when IDLE accepts a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (w_latch) begin
      addr_q    <= req_addr[ADDR_W+1:0];
      wdata_q   <= req_wdata;
      funct3_q  <= req_funct3;
      write_q   <= req_write;
      illegal_q <= w_illegal;
    end
  end

  // Store lane steering: replicate the datum so the enabled lanes carry it.
  always_comb begin
    sram_be    = 4'b1111;
    sram_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        sram_be    = 4'b0001 << addr_q[1:0];
        sram_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        sram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        sram_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction and sign/zero extension of the SRAM read word.
  always_comb begin
    w_byte = sram_rdata[{addr_q[1:0], 3'b000} +: 8];
    w_half = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (funct3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h000000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = sram_rdata;
    endcase
  end

  // Load result register; only the WAIT state updates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (w_capture) begin
      rdata_q <= w_load;
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM word-address width (1024 words).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_addr  input  32  CPU byte address, from ex_mem ALU result.
REQ-006 req_wdata  input  32  CPU store data, from ex_mem rs2 data.
REQ-007 req_read  input  1  load request.
REQ-008 req_write  input  1  store request.
REQ-009 req_funct3  input  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-010 resp_rdata  output  32  aligned, extended load result.
REQ-011 stall  output  1  CPU SHALL freeze the pipeline while this is high.
REQ-012 err  output  1  one-cycle pulse on misaligned or illegal access.
REQ-013 sram_en, sram_we  output  1 each  SRAM strobe and write enable.
REQ-014 sram_be  output  4  byte-lane enables.
REQ-015 sram_addr  output  ADDR_W  word index, req_addr[ADDR_W+1:2]; upper address bits ignored, so addresses wrap.
REQ-016 sram_wdata  output  32  lane-positioned write data.
REQ-017 sram_rdata  input  32  SRAM read data, valid the cycle after sram_en with sram_we=0.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE, with req_read or req_write high:
- stall=1 combinationally in the same cycle.
- Latch addr, wdata, funct3 and the direction.
- If both req_read and req_write are high, the request SHALL be taken as a write.
REQ-020 IDLE, legal request -> ISSUE; illegal request -> DONE, with err=1 during DONE and no SRAM access.
REQ-021 Illegal access is any of:
- funct3 011, 110 or 111.
- Halfword access with addr[0]=1.
- Word access with addr[1:0]!=00.
- Store with funct3 100 or 101.
REQ-022 ISSUE:
- sram_en=1, sram_we=write, stall=1.
- Write -> DONE; read -> WAIT.
REQ-023 WAIT:
- Capture the extracted, extended sram_rdata into the resp_rdata register.
- stall=1; -> DONE.
REQ-024 DONE: stall=0, resp_rdata held; -> IDLE unconditionally, so a request present in DONE is not re-accepted.
REQ-025 In IDLE with no request, stall=0; sram_en, sram_we and err SHALL be 0 in all states except as stated above.
REQ-026 Latency, request cycle to DONE cycle inclusive:
- Store: 3 cycles (2 stall cycles).
- Load: 4 cycles (3 stall cycles).
- Illegal: 2 cycles.
REQ-027 Byte lanes:
- sb: be=0001<<addr[1:0], wdata = byte replicated 4x.
- sh: be = addr[1] ? 1100 : 0011, wdata = halfword replicated 2x.
- sw: be=1111.
REQ-028 Load extract: select byte addr[1:0] or halfword addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-029 resp_rdata SHALL change only in WAIT and SHALL hold through stores and illegal accesses.

Reset
REQ-030 While reset is high, all of the following SHALL hold immediately, independent of clk:
- State = IDLE, resp_rdata=0.
- sram_en=0, sram_we=0, err=0.
- Latched registers cleared.
REQ-031 Reset asserted in ISSUE SHALL drop sram_en and sram_we before the next clk edge, so no write commits.
REQ-032 After reset is released, a request in the first cycle SHALL be accepted normally.

Verification
REQ-033 sw of 0xDEADBEEF to addr 0x104 -> ISSUE: sram_addr=0x041, be=1111; stall high for 2 cycles; SRAM word = 0xDEADBEEF.
REQ-034 sb of 0x000000A5 to 0x106, then lb and lbu from 0x106:
- Store: be=0100.
- lb: resp_rdata=0xFFFFFFA5.
- lbu: resp_rdata=0x000000A5, 3 stall cycles each.
REQ-035 lh from 0x103 -> err pulses 1 cycle, sram_en never high, resp_rdata unchanged, stall high for 1 cycle.
REQ-036 sh of 0x00008001 to 0x102, then lhu from 0x102 -> be=1100, resp_rdata=0x00008001; lw from 0x100 returns 0x8001xxxx with the low half preserved.
REQ-037 req_read and req_write both high at 0x000 -> write performed, resp_rdata unchanged.
REQ-038 Assert reset during ISSUE of sw to 0x200 -> sram_en falls immediately and word 0x080 is unmodified; back-to-back loads held during DONE are each serviced exactly once.
